// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM states,
// ALU operation codes, mux select encodings and the bundled strobe struct.
package mc_ctrl_pkg;

    // Instruction opcodes (IR[15:12]); anything above OP_CALL is undefined
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_CALL = 4'hA;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    // Next-PC mux selects
    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Register write-back mux selects
    localparam logic [1:0] WB_FROM_ALU = 2'b00;
    localparam logic [1:0] WB_FROM_MEM = 2'b01;
    localparam logic [1:0] WB_FROM_PC  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB_ALU = 3'd3,
        ST_ADDR   = 3'd4,
        ST_MEM    = 3'd5,
        ST_WB_MEM = 3'd6,
        ST_BRANCH = 3'd7
    } state_t;

    // Every datapath strobe and select driven by the control unit
    typedef struct packed {
        logic       instr_mem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       data_mem_read;
        logic       data_mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

    // Opcodes B..F have no defined behaviour
    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OP_CALL);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational output decoder for the multicycle control FSM.
// Maps (state, opcode, zero, mem_ready) onto the full set of datapath strobes.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Everything defaults to 0; each state raises only the strobes it owns
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.instr_mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_PLUS1;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_JMP) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_JUMP;
                end else if (opcode == OP_CALL) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_src    = PC_JUMP;
                    ctrl.reg_write = 1'b1;
                    ctrl.wb_sel    = WB_FROM_PC;
                end else if (is_illegal(opcode)) begin
                    ctrl.illegal = 1'b1;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_SUB) begin
                    ctrl.alu_op = ALU_SUB;
                end else if ((opcode == OP_AND) || (opcode == OP_ANDI)) begin
                    ctrl.alu_op = ALU_AND;
                end else begin
                    ctrl.alu_op = ALU_ADD;
                end
                ctrl.alu_src_b = (opcode == OP_ADDI) || (opcode == OP_ANDI);
            end
            ST_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_FROM_ALU;
            end
            ST_ADDR: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src_b = 1'b1;
            end
            ST_MEM: begin
                if (opcode == OP_LW) begin
                    ctrl.data_mem_read = 1'b1;
                end else begin
                    ctrl.data_mem_write = 1'b1;
                end
            end
            ST_WB_MEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = WB_FROM_MEM;
            end
            ST_BRANCH: begin
                ctrl.alu_op = ALU_SUB;
                if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero)) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_BRANCH;
                end
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control unit for the 16-bit RISC datapath.
// Holds the FSM state register; strobes come from mc_ctrl_decode and are
// held at 0 while rst_n is low so a reset aborts any write-back or store.
// Optional feature: define MC_PERF_CNT_EN to add the 16-bit retired counter.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        instr_mem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        data_mem_read,
    output logic        data_mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    state_t state;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;

    mc_ctrl_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Instruction sequencing: fetch, decode, then the per-class execute path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_AND, OP_ADD, OP_SUB, OP_ADDI, OP_ANDI: state <= ST_EXEC;
                        OP_LW, OP_SW:                             state <= ST_ADDR;
                        OP_BEQ, OP_BNE:                           state <= ST_BRANCH;
                        default:                                  state <= ST_FETCH;
                    endcase
                end
                ST_EXEC:   state <= ST_WB_ALU;
                ST_WB_ALU: state <= ST_FETCH;
                ST_ADDR:   state <= ST_MEM;
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= (opcode == OP_LW) ? ST_WB_MEM : ST_FETCH;
                    end
                end
                ST_WB_MEM: state <= ST_FETCH;
                ST_BRANCH: state <= ST_FETCH;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Suppress every strobe while reset is asserted, even in FETCH
    always_comb begin
        ctrl = rst_n ? ctrl_raw : '0;
    end

    assign instr_mem_req  = ctrl.instr_mem_req;
    assign ir_write       = ctrl.ir_write;
    assign pc_write       = ctrl.pc_write;
    assign pc_src         = ctrl.pc_src;
    assign alu_src_b      = ctrl.alu_src_b;
    assign alu_op         = ctrl.alu_op;
    assign data_mem_read  = ctrl.data_mem_read;
    assign data_mem_write = ctrl.data_mem_write;
    assign reg_write      = ctrl.reg_write;
    assign wb_sel         = ctrl.wb_sel;
    assign illegal        = ctrl.illegal;

`ifdef MC_PERF_CNT_EN
    logic        returning;
    logic [15:0] retired_q;

    // An instruction retires on the cycle its last state hands back to FETCH
    always_comb begin
        returning = 1'b0;
        case (state)
            ST_DECODE: returning = (opcode == OP_JMP) || (opcode == OP_CALL) || is_illegal(opcode);
            ST_WB_ALU: returning = 1'b1;
            ST_WB_MEM: returning = 1'b1;
            ST_BRANCH: returning = 1'b1;
            ST_MEM:    returning = mem_ready && (opcode != OP_LW);
            default:   returning = 1'b0;
        endcase
    end

    // Free-running retired-instruction count, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'h0000;
        end else if (returning) begin
            retired_q <= retired_q + 16'h0001;
        end
    end

    assign retired = retired_q;
`endif

endmodule
